// File: rtl/hazard_ctrl_pkg.sv
// Shared opcode/funct constants and widths for the hazard controller.
package hazard_ctrl_pkg;

   localparam int MD_CNT_W = 6;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL    = 6'h00;
   localparam logic [5:0] FN_SRL    = 6'h02;
   localparam logic [5:0] FN_SRA    = 6'h03;
   localparam logic [5:0] FN_JR     = 6'h08;
   localparam logic [5:0] FN_JALR   = 6'h09;
   localparam logic [5:0] FN_MFHI   = 6'h10;
   localparam logic [5:0] FN_MTHI   = 6'h11;
   localparam logic [5:0] FN_MFLO   = 6'h12;
   localparam logic [5:0] FN_MTLO   = 6'h13;
   localparam logic [5:0] FN_MULT   = 6'h18;
   localparam logic [5:0] FN_MULTU  = 6'h19;
   localparam logic [5:0] FN_DIV    = 6'h1A;
   localparam logic [5:0] FN_DIVU   = 6'h1B;

endpackage

// File: rtl/hazard_ctrl_decode.sv
// Classifies the ID-stage instruction by register use and hazard class.
module hazard_decode
   import hazard_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] fn,
   output logic       uses_rs,
   output logic       uses_rt,
   output logic       is_br,
   output logic       is_hilo,
   output logic       is_md,
   output logic       is_div
);

   always_comb begin
      uses_rs = 1'b1;
      uses_rt = 1'b0;
      is_br   = 1'b0;
      is_hilo = 1'b0;
      is_md   = 1'b0;
      is_div  = 1'b0;
      case (op)
         OP_J, OP_JAL: uses_rs = 1'b0;
         OP_REGIMM, OP_BLEZ, OP_BGTZ: is_br = 1'b1;
         OP_BEQ, OP_BNE: begin
            is_br   = 1'b1;
            uses_rt = 1'b1;
         end
         OP_SB, OP_SH, OP_SW: uses_rt = 1'b1;
         OP_RTYPE: begin
            uses_rt = 1'b1;
            case (fn)
               FN_SLL, FN_SRL, FN_SRA: uses_rs = 1'b0;
               FN_JR, FN_JALR: is_br = 1'b1;
               FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: is_hilo = 1'b1;
               FN_MULT, FN_MULTU: begin
                  is_hilo = 1'b1;
                  is_md   = 1'b1;
               end
               FN_DIV, FN_DIVU: begin
                  is_hilo = 1'b1;
                  is_md   = 1'b1;
                  is_div  = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for hazards forwarding cannot cover.
// Optional HI/LO busy tracking enabled by HAZARD_MD_STALL_EN.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_MUL_LAT = 4,
   parameter int MD_DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  FD_OpCode,
   input  logic [5:0]  FD_Funct,
   input  logic [4:0]  FD_Rs,
   input  logic [4:0]  FD_Rt,
   input  logic        DE_MemRead,
   input  logic        DE_RegWrite,
   input  logic [4:0]  DE_RegWrAddr,
   input  logic        EM_MemRead,
   input  logic [4:0]  EM_RegWrAddr,
   output logic        PC_Stall,
   output logic        FD_Stall,
   output logic        DE_Flush,
   output logic        MD_Busy,
   output logic [31:0] Stall_Count
);

   logic uses_rs, uses_rt, is_br, is_hilo, is_md, is_div;
   logic match_de, match_em;
   logic load_use, br_ex, br_mem, md_hz, stall;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   hazard_decode u_dec (
      .op      (FD_OpCode),
      .fn      (FD_Funct),
      .uses_rs (uses_rs),
      .uses_rt (uses_rt),
      .is_br   (is_br),
      .is_hilo (is_hilo),
      .is_md   (is_md),
      .is_div  (is_div)
   );

   // $0 is hardwired, so it never forms a dependency
   always_comb begin
      match_de = (DE_RegWrAddr != 5'd0) &&
                 ((uses_rs && DE_RegWrAddr == FD_Rs) ||
                  (uses_rt && DE_RegWrAddr == FD_Rt));
      match_em = (EM_RegWrAddr != 5'd0) &&
                 ((uses_rs && EM_RegWrAddr == FD_Rs) ||
                  (uses_rt && EM_RegWrAddr == FD_Rt));
   end

   assign load_use = DE_MemRead && match_de;
   assign br_ex    = is_br && DE_RegWrite && match_de;
   assign br_mem   = is_br && EM_MemRead && match_em;
   assign stall    = load_use || br_ex || br_mem || md_hz;

   assign PC_Stall = stall;
   assign FD_Stall = stall;
   assign DE_Flush = stall;

`ifdef HAZARD_MD_STALL_EN
   logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

   // a stalled mult/div does not issue, so it must not reload
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (is_md && !stall) begin
         md_cnt_d = is_div ? MD_CNT_W'(MD_DIV_LAT)
                           : MD_CNT_W'(MD_MUL_LAT);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) md_cnt_q <= '0;
      else       md_cnt_q <= md_cnt_d;
   end

   assign md_hz   = is_hilo && (md_cnt_q != '0);
   assign MD_Busy = (md_cnt_q != '0);
`else
   logic unused_md;
   assign unused_md = ^{MD_MUL_LAT[0], MD_DIV_LAT[0], is_md, is_div};
   assign md_hz     = 1'b0;
   assign MD_Busy   = 1'b0;
`endif

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign Stall_Count = stall_cnt_q;

endmodule
